// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
        S_LUI, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Conditional-branch resolution from the ALU flags of RD1 - RD2.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
        case (f3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic opcode_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: opcode_supported = 1'b1;
            default:                            opcode_supported = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        is_mem_state = (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7[5]; rtype selects
// whether funct7[5] distinguishes add from sub.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       rtype,
    output logic [2:0] alu_ctrl
);

    // funct3 to ALU operation; sltu and other unlisted codes fall back to add
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  alu_ctrl = (rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b101:  alu_ctrl = ALU_SRL;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: one state per cycle,
// Moore outputs with mem_ready qualification of write strobes in memory states.
// Define MULTICYCLE_CTRL_TRAP_EN to send illegal opcodes and memory timeouts
// to a HALT state that is left only by reset.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       mem_err
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam state_t TRAP_STATE = S_HALT;
`else
    localparam state_t TRAP_STATE = S_FETCH;
`endif

    state_t      state_reg, state_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        mem_err_reg, mem_err_next;
    logic        timeout_hit;
    logic [2:0]  dec_ctrl;
    logic        unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (funct7[5]),
        .rtype    (state_reg == S_EXECR),
        .alu_ctrl (dec_ctrl)
    );

    // A memory state gives up on the cycle its wait count would reach TIMEOUT,
    // unless mem_ready shows up in that same cycle.
    assign timeout_hit = (TIMEOUT > 0) && is_mem_state(state_reg) && !mem_ready &&
                         (wait_cnt_reg == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_FETCH;
        else     state_reg <= state_next;
    end

    // Memory wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    // Next-state, wait-count and error-flag logic
    always_comb begin
        state_next    = state_reg;
        mem_err_next  = mem_err_reg | timeout_hit;
        wait_cnt_next = '0;
        if ((TIMEOUT > 0) && is_mem_state(state_reg) && !mem_ready && !timeout_hit)
            wait_cnt_next = wait_cnt_reg + 16'd1;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
                        else if (timeout_hit) state_next = TRAP_STATE;
            S_DECODE: begin
                case (OP)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = TRAP_STATE;
                endcase
            end
            S_MEMADR:   state_next = OP[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
                        else if (timeout_hit) state_next = TRAP_STATE;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
                        else if (timeout_hit) state_next = TRAP_STATE;
            S_MEMWB:    state_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
            S_JALR:     state_next = S_JALR_LINK;
            S_JALR_LINK: state_next = S_ALUWB;
            S_ALUWB, S_BRANCH, S_LUI: state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted so no
    // strobe can reach the datapath across the reset edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    // Branch target by default; JAL needs its J-immediate target
                    // in ALUOut because the JAL state jumps to it.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (OP == OP_JAL) ? IMM_J : IMM_B;
                    illegal   = !opcode_supported(OP);
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = OP[5] ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = (state_reg == S_EXECR) ? SRCB_RD2 : SRCB_IMM;
                    alu_ctrl  = dec_ctrl;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = SRCA_RD1;
                    alu_ctrl  = ALU_SUB;
                    pc_write  = branch_taken(funct3, zero, lt);
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALURESULT;
                    pc_write   = 1'b1;
                end
                S_JALR_LINK: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                end
                S_LUI: begin
                    imm_src    = IMM_U;
                    result_src = RES_IMM;
                    reg_write  = 1'b1;
                end
                S_HALT:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_err = mem_err_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every cycle's full output vector
// is compared with a hand-written expectation for the state it should be in.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, lt, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_ctrl, imm_src;
    logic       illegal, mem_err;

    typedef struct packed {
        logic       req, mwr, adr, irw, pcw, rw;
        logic [1:0] a, b;
        logic [2:0] ctrl, imm;
        logic [1:0] res;
        logic       ill, err;
    } outs_t;

    outs_t obs;
    int    checks = 0;
    int    errors = 0;
    logic  exp_err = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .OP(OP), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .imm_src(imm_src), .result_src(result_src), .illegal(illegal),
        .mem_err(mem_err)
    );

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, mem_err};

    function automatic outs_t o(input logic req, mwr, adr, irw, pcw, rw,
                                input logic [1:0] a, b, input logic [2:0] ctrl, imm,
                                input logic [1:0] res, input logic ill);
        return {req, mwr, adr, irw, pcw, rw, a, b, ctrl, imm, res, ill, exp_err};
    endfunction

    function automatic outs_t e_fetch(input logic r);
        return o(1, 0, 0, r, r, 0, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10, 0);
    endfunction
    function automatic outs_t e_decode(input logic ill, input logic [2:0] imm);
        return o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, imm, 2'b00, ill);
    endfunction
    function automatic outs_t e_execr(input logic [2:0] c);
        return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, c, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_execi(input logic [2:0] c);
        return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, c, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_aluwb();
        return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_memadr(input logic [2:0] imm);
        return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, imm, 2'b00, 0);
    endfunction
    function automatic outs_t e_memread();
        return o(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_memwb();
        return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01, 0);
    endfunction
    function automatic outs_t e_memwrite();
        return o(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_branch(input logic t);
        return o(0, 0, 0, 0, t, 0, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_jal();
        return o(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_jalr();
        return o(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 3'b000, 3'b000, 2'b10, 0);
    endfunction
    function automatic outs_t e_jalr_link();
        return o(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_lui();
        return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b100, 2'b11, 0);
    endfunction
    function automatic outs_t e_zero();
        return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 0);
    endfunction
    function automatic outs_t e_halt();
        return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 1);
    endfunction

    // Compare the current output vector, one line per check
    task automatic chk(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s obs=%05h exp=%05h", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Inputs already driven (posedge+1); check at posedge+2, advance one cycle
    task automatic step(input string tag, input outs_t exp);
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    // FETCH (instruction arrives at once) followed by DECODE
    task automatic fetch_decode(input string tag, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [2:0] dec_imm);
        OP = op; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
        step({tag, "_fetch"}, e_fetch(1'b1));
        mem_ready = 1'b0;
        step({tag, "_decode"}, e_decode(1'b0, dec_imm));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_pulse", e_zero());
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; OP = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        zero = 1'b0; lt = 1'b0;
        #2;
        chk("reset", e_zero());
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;

        // add x3,x1,x2 (0x002081B3)
        fetch_decode("add", 7'b0110011, 3'b000, 7'b0000000, 3'b010);
        step("add_execr", e_execr(3'b000));
        step("add_aluwb", e_aluwb());

        // sub: funct7[5] selects sub in EXECR
        fetch_decode("sub", 7'b0110011, 3'b000, 7'b0100000, 3'b010);
        step("sub_execr", e_execr(3'b001));
        step("sub_aluwb", e_aluwb());

        // addi with funct7 bits set: still add in EXECI
        fetch_decode("addi", 7'b0010011, 3'b000, 7'b0100000, 3'b010);
        step("addi_execi", e_execi(3'b000));
        step("addi_aluwb", e_aluwb());

        // xor / srl / and / slt / sll / or register forms
        fetch_decode("xor", 7'b0110011, 3'b100, 7'b0000000, 3'b010);
        step("xor_execr", e_execr(3'b101));
        step("xor_aluwb", e_aluwb());
        fetch_decode("srli", 7'b0010011, 3'b101, 7'b0000000, 3'b010);
        step("srli_execi", e_execi(3'b111));
        step("srli_aluwb", e_aluwb());
        fetch_decode("and", 7'b0110011, 3'b111, 7'b0000000, 3'b010);
        step("and_execr", e_execr(3'b010));
        step("and_aluwb", e_aluwb());
        fetch_decode("slti", 7'b0010011, 3'b010, 7'b0000000, 3'b010);
        step("slti_execi", e_execi(3'b100));
        step("slti_aluwb", e_aluwb());
        fetch_decode("sll", 7'b0110011, 3'b001, 7'b0000000, 3'b010);
        step("sll_execr", e_execr(3'b110));
        step("sll_aluwb", e_aluwb());
        fetch_decode("ori", 7'b0010011, 3'b110, 7'b0000000, 3'b010);
        step("ori_execi", e_execi(3'b011));
        step("ori_aluwb", e_aluwb());

        // lw with mem_ready delayed three cycles
        fetch_decode("lw", 7'b0000011, 3'b010, 7'b0000000, 3'b010);
        step("lw_memadr", e_memadr(3'b000));
        for (int i = 0; i < 3; i++) step("lw_memread_wt", e_memread());
        mem_ready = 1'b1;
        step("lw_memread_rdy", e_memread());
        mem_ready = 1'b0;
        step("lw_memwb", e_memwb());

        // sw
        fetch_decode("sw", 7'b0100011, 3'b010, 7'b0000000, 3'b010);
        step("sw_memadr", e_memadr(3'b001));
        mem_ready = 1'b1;
        step("sw_memwrite", e_memwrite());
        mem_ready = 1'b0;

        // bne with zero=1: not taken; bge with lt=0: taken
        zero = 1'b1;
        fetch_decode("bne", 7'b1100011, 3'b001, 7'b0000000, 3'b010);
        step("bne_branch", e_branch(1'b0));
        zero = 1'b0; lt = 1'b0;
        fetch_decode("bge", 7'b1100011, 3'b101, 7'b0000000, 3'b010);
        step("bge_branch", e_branch(1'b1));
        lt = 1'b1;
        fetch_decode("blt", 7'b1100011, 3'b100, 7'b0000000, 3'b010);
        step("blt_branch", e_branch(1'b1));
        lt = 1'b0;

        // lui
        fetch_decode("lui", 7'b0110111, 3'b000, 7'b0000000, 3'b010);
        step("lui_lui", e_lui());

        // jal: J-immediate target computed in DECODE
        fetch_decode("jal", 7'b1101111, 3'b000, 7'b0000000, 3'b011);
        step("jal_jal", e_jal());
        step("jal_aluwb", e_aluwb());

        // jalr
        fetch_decode("jalr", 7'b1100111, 3'b000, 7'b0000000, 3'b010);
        step("jalr_jalr", e_jalr());
        step("jalr_link", e_jalr_link());
        step("jalr_aluwb", e_aluwb());

        // mem_ready on the very cycle the wait would time out: access wins
        OP = 7'b0110111; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) step("late_fetch_wt", e_fetch(1'b0));
        mem_ready = 1'b1;
        step("late_fetch_rdy", e_fetch(1'b1));
        mem_ready = 1'b0;
        step("late_decode", e_decode(1'b0, 3'b010));
        step("late_lui", e_lui());

        // Unsupported opcode
        OP = 7'b1111111; mem_ready = 1'b1;
        step("ill_fetch", e_fetch(1'b1));
        mem_ready = 1'b0;
        step("ill_decode", e_decode(1'b1, 3'b010));
`ifdef MULTICYCLE_CTRL_TRAP_EN
        step("ill_halt0", e_halt());
        mem_ready = 1'b1;
        step("ill_halt1", e_halt());
        mem_ready = 1'b0;
        pulse_reset();
`endif
        OP = 7'b0110011;
        step("ill_resume", e_fetch(1'b0));

        // Fifteen FETCH cycles without mem_ready raise mem_err
        for (int i = 0; i < 14; i++) step("to_fetch_wt", e_fetch(1'b0));
        exp_err = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        step("to_halt0", e_halt());
        mem_ready = 1'b1;
        step("to_halt1", e_halt());
        mem_ready = 1'b0;
        pulse_reset();
        exp_err = 1'b0;
`else
        step("to_err_fetch", e_fetch(1'b0));
`endif

        // Reset in the middle of a MEMREAD wait
        fetch_decode("rst_lw", 7'b0000011, 3'b010, 7'b0000000, 3'b010);
        step("rst_lw_memadr", e_memadr(3'b000));
        step("rst_lw_memread", e_memread());
        #1;
        rst = 1'b1; mem_ready = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("rst_mid_read", e_zero());
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        step("rst_after", e_fetch(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so the run always ends on its own
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
